// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 (CPOL=0, CPHA=0, MSB-first) master shift engine
// sitting between the TX and RX FIFOs. One TX word per chip-select frame.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : synchronous abort back to IDLE, clears rx_overrun
//   enable         : permits new transfers (checked only in IDLE)
//   tx_data/tx_empty/tx_rd_en : TX FIFO head word, empty flag, pop strobe
//   rx_data/rx_full/rx_wr_en  : received word, RX FIFO full flag, push strobe
//   rx_overrun     : sticky, a received word was dropped on a full RX FIFO
//   busy           : engine is not IDLE
//   sclk/mosi/miso/cs_n       : SPI pins
module spi_master_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_empty,
  output logic             tx_rd_en,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_full,
  output logic             rx_wr_en,
  output logic             rx_overrun,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             div_last;

  assign div_last = (div_cnt == DIV_LAST);

  // Pops and pushes are suppressed while clear is high (or in reset) so that
  // an aborted cycle never consumes or emits a FIFO word.
  assign tx_rd_en = rst_n && !clear && (state == IDLE) && enable && !tx_empty;
  assign rx_wr_en = !clear && (state == STORE) && !rx_full;
  assign rx_data  = rx_shift;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      rx_overrun <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      rx_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (tx_rd_en) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[WIDTH-1];
            cs_n     <= 1'b0;
            state    <= LOAD;
          end
        end

        // Leading low phase of SCLK; its last edge is the first rising edge.
        LOAD: begin
          if (div_last) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[WIDTH-2:0], miso};
            bit_cnt  <= BW'(1);
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                mosi  <= 1'b0;
                cs_n  <= 1'b1;
                state <= STORE;
              end else begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                mosi     <= tx_shift[WIDTH-2];
              end
            end else begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[WIDTH-2:0], miso};
              bit_cnt  <= bit_cnt + BW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        STORE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (rx_full) rx_overrun <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (WIDTH=8, CLK_DIV=2) with a mode-0 slave.
module tb_spi_master_ctrl;

  localparam int W  = 8;
  localparam int CD = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         enable;
  logic [W-1:0] tx_data;
  logic         tx_empty;
  logic         tx_rd_en;
  logic [W-1:0] rx_data;
  logic         rx_full;
  logic         rx_wr_en;
  logic         rx_overrun;
  logic         busy;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .enable     (enable),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty),
    .tx_rd_en   (tx_rd_en),
    .rx_data    (rx_data),
    .rx_full    (rx_full),
    .rx_wr_en   (rx_wr_en),
    .rx_overrun (rx_overrun),
    .busy       (busy),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: bit k of the frame (MSB first) is presented after the k-th
  // rising SCLK edge; MOSI is recorded on every rising edge.
  logic [W-1:0] slv_word = 8'h3C;
  logic [3:0]   rcnt     = 4'd0;
  logic [W-1:0] mosi_rec = '0;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      rcnt <= 4'd0;
    end else begin
      rcnt     <= rcnt + 4'd1;
      mosi_rec <= {mosi_rec[W-2:0], mosi};
    end
  end

  assign miso = (rcnt < 4'd8) ? slv_word[~rcnt[2:0]] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one word from its IDLE pop (cycle 0, current negedge) to cycle 40.
  task automatic send_word(input logic [W-1:0] d, output int pop_ok, output int wr_cnt,
                           output int wr_cyc, output logic [W-1:0] wr_data, output int pat_err);
    int exp_sclk;
    pop_ok  = 0;
    wr_cnt  = 0;
    wr_cyc  = -1;
    wr_data = '0;
    pat_err = 0;
    tx_data  = d;
    tx_empty = 1'b0;
    #1;
    pop_ok = int'(tx_rd_en);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) tx_empty = 1'b1;
      #1;
      if (tx_rd_en) pat_err++;
      if (rx_wr_en) begin
        wr_cnt++;
        wr_cyc  = c;
        wr_data = rx_data;
      end
      if (c <= 2 * W * CD) begin
        exp_sclk = ((c - 1) / CD) % 2;
        if (sclk !== 1'(exp_sclk) || cs_n !== 1'b0 || busy !== 1'b1) pat_err++;
      end else if (c == 2 * W * CD + 1) begin
        if (sclk !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b1 || mosi !== 1'b0) pat_err++;
      end else begin
        if (sclk !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0) pat_err++;
      end
    end
  endtask

  initial begin
    int pop_ok, wr_cnt, wr_cyc, pat_err, bad, np, idx, pend, hi_run, seen_low, ngaps, good_rx;
    int pops[4];
    int gaps[4];
    logic [W-1:0] wr_data;
    logic [W-1:0] words[3];

    rst_n    = 1'b0;
    clear    = 1'b0;
    enable   = 1'b1;
    tx_empty = 1'b0;
    tx_data  = 8'hA5;
    rx_full  = 1'b0;

    // Reset held with a word waiting.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_tx_rd_en", tx_rd_en, 0);
    chk("rst_rx_wr_en", rx_wr_en, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_rx_data", rx_data, 0);

    // Single word 0xA5 out, slave returns 0x3C.
    rst_n = 1'b1;
    send_word(8'hA5, pop_ok, wr_cnt, wr_cyc, wr_data, pat_err);
    chk("w1_first_pop", pop_ok, 1);
    chk("w1_wr_count", wr_cnt, 1);
    chk("w1_wr_cycle", wr_cyc, 33);
    chk("w1_rx_data", wr_data, 8'h3C);
    chk("w1_mosi_bits", mosi_rec, 8'hA5);
    chk("w1_timeline", pat_err, 0);

    // Three queued words back to back.
    words[0] = 8'h81;
    words[1] = 8'h7E;
    words[2] = 8'hC3;
    np = 0; idx = 0; pend = 0; hi_run = 0; seen_low = 0; ngaps = 0; wr_cnt = 0; good_rx = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      pops[i] = -1;
      gaps[i] = -1;
    end
    for (int c = 0; c <= 110; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        tx_data  = words[0];
        tx_empty = 1'b0;
      end
      if (pend != 0) begin
        pend = 0;
        idx++;
        if (idx < 3) tx_data = words[idx];
        else tx_empty = 1'b1;
      end
      #1;
      if (tx_rd_en) begin
        if (np < 4) pops[np] = c;
        np++;
        pend = 1;
      end
      if (rx_wr_en) begin
        wr_cnt++;
        if (rx_data === 8'h3C) good_rx++;
      end
      if (cs_n) begin
        hi_run++;
      end else begin
        if (seen_low != 0 && hi_run > 0) begin
          if (ngaps < 4) gaps[ngaps] = hi_run;
          ngaps++;
        end
        hi_run   = 0;
        seen_low = 1;
      end
    end
    chk("q3_pop_count", np, 3);
    chk("q3_pop0_cycle", pops[0], 0);
    chk("q3_pop1_cycle", pops[1], 34);
    chk("q3_pop2_cycle", pops[2], 68);
    chk("q3_gap_count", ngaps, 2);
    chk("q3_gap0_len", gaps[0], 2);
    chk("q3_gap1_len", gaps[1], 2);
    chk("q3_wr_count", wr_cnt, 3);
    chk("q3_rx_words", good_rx, 3);
    chk("q3_last_mosi", mosi_rec, 8'hC3);

    // RX FIFO full at STORE: word dropped, sticky overrun until clear.
    @(negedge clk);
    rx_full = 1'b1;
    send_word(8'h11, pop_ok, wr_cnt, wr_cyc, wr_data, pat_err);
    chk("ovr_pop", pop_ok, 1);
    chk("ovr_wr_count", wr_cnt, 0);
    chk("ovr_timeline", pat_err, 0);
    chk("ovr_flag_set", rx_overrun, 1);
    rx_full = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("ovr_flag_sticky", rx_overrun, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("ovr_flag_cleared", rx_overrun, 0);

    // Clear just after the 4th rising SCLK edge, then a clean frame follows.
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_empty = 1'b0;
    #1;
    chk("clr_pop", tx_rd_en, 1);
    wr_cnt = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) tx_empty = 1'b1;
      #1;
      if (rx_wr_en) wr_cnt++;
    end
    chk("clr_sclk_high_before", sclk, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    if (rx_wr_en) wr_cnt++;
    chk("clr_cs_n", cs_n, 1);
    chk("clr_sclk", sclk, 0);
    chk("clr_mosi", mosi, 0);
    chk("clr_busy", busy, 0);
    chk("clr_no_wr", wr_cnt, 0);
    slv_word = 8'h96;
    send_word(8'h5A, pop_ok, wr_cnt, wr_cyc, wr_data, pat_err);
    chk("clr_next_pop", pop_ok, 1);
    chk("clr_next_wr_cycle", wr_cyc, 33);
    chk("clr_next_rx_data", wr_data, 8'h96);
    chk("clr_next_mosi", mosi_rec, 8'h5A);
    chk("clr_next_timeline", pat_err, 0);

    // enable low with a word waiting: nothing starts.
    enable   = 1'b0;
    tx_data  = 8'h33;
    tx_empty = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (tx_rd_en !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("dis_idle", bad, 0);

    // Asynchronous reset in the middle of SHIFT.
    enable = 1'b1;
    #1;
    chk("async_pop", tx_rd_en, 1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) tx_empty = 1'b1;
    end
    #1;
    chk("async_busy_before", busy, 1);
    chk("async_cs_before", cs_n, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", cs_n, 1);
    chk("async_sclk", sclk, 0);
    chk("async_mosi", mosi, 0);
    chk("async_busy", busy, 0);
    chk("async_rx_data", rx_data, 0);
    chk("async_rx_wr_en", rx_wr_en, 0);
    chk("async_tx_rd_en", tx_rd_en, 0);
    chk("async_rx_overrun", rx_overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master shift engine (mode 0: CPOL=0, CPHA=0, MSB first) between the TX and RX FIFOs of the SPI block. It pops words from the TX FIFO, shifts each one out on MOSI inside its own chip-select frame, and samples MISO in parallel. Each received word is pushed into the RX FIFO; a word is dropped and flagged when that FIFO is full.

## Interface
Parameters:
- WIDTH, 8, bits per SPI word; matches FIFO WIDTH
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range ≥1

Ports:
- clk  in  1  global clock
- rst_n  in  1  global reset; asynchronous, active-low
- clear  in  1  synchronous abort; returns the block to IDLE and clears rx_overrun
- enable  in  1  permits new transfers; sampled only in IDLE
- tx_data  in  WIDTH  TX FIFO head word; combinationally valid while !tx_empty
- tx_empty  in  1  TX FIFO empty flag
- tx_rd_en  out  1  one-cycle pop of the TX FIFO
- rx_data  out  WIDTH  received word; valid while rx_wr_en=1
- rx_full  in  1  RX FIFO full flag
- rx_wr_en  out  1  one-cycle push into the RX FIFO
- rx_overrun  out  1  sticky; a received word was dropped
- busy  out  1  high whenever state≠IDLE
- sclk  out  1  SPI clock; idles low
- mosi  out  1  serial data out
- miso  in  1  serial data in
- cs_n  out  1  active-low chip select

## Operation
States:
- IDLE: tx_rd_en=enable&&!tx_empty (combinational).
  - When tx_rd_en=1: tx_shift←tx_data at the same edge as the FIFO pop; go to LOAD.
- LOAD: cs_n=0, sclk=0, mosi=tx_shift[WIDTH-1].
  - Lasts CLK_DIV cycles.
  - Last cycle: sclk←1, rx_shift←{rx_shift[WIDTH-2:0],miso}, bit_cnt←1; go to SHIFT.
- SHIFT: sclk toggles at each half-period boundary (div_cnt==CLK_DIV-1).
  - Falling toggle, bit_cnt<WIDTH: tx_shift shifts left; mosi presents the next bit.
  - Rising toggle: sample miso into rx_shift; bit_cnt+1.
  - Falling toggle, bit_cnt==WIDTH: go to STORE.
- STORE: one cycle, cs_n=1, sclk=0.
  - rx_wr_en=!rx_full.
  - If rx_full: word dropped, rx_overrun←1.
  - Then go to IDLE.

Data and control rules:
- rx_data is driven directly by rx_shift.
- mosi=0 in IDLE and STORE; cs_n=1 in IDLE and STORE.
- Deasserting enable mid-word does not abort; the current word completes.
- div_cnt width is $clog2(CLK_DIV)+1. bit_cnt width is $clog2(WIDTH)+1. div_cnt resets to 0 on every state entry.
- Priority: rst_n > clear > FSM.
- clear, in any state: next cycle state=IDLE, sclk=0, cs_n=1, mosi=0, rx_overrun=0, counters=0.
  - Data in flight is discarded with no rx_wr_en.
  - The TX word already popped is lost.
- rst_n low, including mid-word: all outputs take reset values immediately.

## Timing
- Reset values: sclk=0, cs_n=1, mosi=0, tx_rd_en=0 (tx_empty=1 or enable=0), rx_wr_en=0, rx_overrun=0, busy=0, rx_data=0.
- Per-word timeline, with cycle 0 = IDLE pop cycle:
  - LOAD occupies cycles 1..CLK_DIV.
  - STORE occurs at cycle 1+2·WIDTH·CLK_DIV.
  - Next pop is at cycle 2+2·WIDTH·CLK_DIV at the earliest.
- Back-to-back words: cs_n is high for exactly 2 cycles between frames (STORE and IDLE).
- MISO is sampled on the clk edge at which sclk goes 0→1.
- MOSI changes only on the clk edge at which sclk goes 1→0, or on LOAD entry.
- SCLK high and low phases are each exactly CLK_DIV cycles.
- tx_rd_en and rx_wr_en are never high for more than one consecutive cycle.

## Test plan
- Reset: hold rst_n=0 with tx_empty=0 and enable=1. Required: cs_n=1, sclk=0, busy=0. After release, tx_rd_en=1 in the first cycle.
- Single word, WIDTH=8, CLK_DIV=2: tx_data=0xA5, slave model returns 0x3C.
  - MOSI at rising edges reads 1,0,1,0,0,1,0,1.
  - rx_wr_en pulses once at cycle 33 with rx_data=0x3C.
- Three queued words, CLK_DIV=2: tx_rd_en pulses at cycles 0, 34, 68; cs_n high exactly 2 cycles between frames; 3 rx_wr_en pulses.
- rx_full=1 during STORE: rx_wr_en stays 0 and rx_overrun=1 until clear. After clear, rx_overrun=0.
- clear at the 4th rising edge: next cycle cs_n=1, sclk=0, no rx_wr_en. The next word's frame starts clean from LOAD.
- enable=0 with tx_empty=0: no tx_rd_en and cs_n stays 1. Also pulse rst_n low mid-SHIFT: outputs return to reset values asynchronously.
